// File: rtl/lc3b_pmem_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache.
// The grant is held from the IDLE decision until pmem_resp closes the line transfer.
module lc3b_pmem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t state_q, state_d;
  grant_t last_grant_q, last_grant_d;
  logic   i_req, d_req;
  logic   unused_addr_bits;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  assign unused_addr_bits = ^{i_pmem_address[3:0], d_pmem_address[3:0]};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (FIXED_PRIO || last_grant_q == GRANT_I) begin
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
          end else begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
          end
        end else if (i_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end
      end
      // A dropped request does not abort; only pmem_resp ends a transfer.
      SERVE_I: if (pmem_resp) state_d = IDLE;
      SERVE_D: if (pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Strobes look only at the registered state and the granted requester.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    case (state_q)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = {i_pmem_address[15:4], 4'b0000};
      end
      SERVE_D: begin
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = {d_pmem_address[15:4], 4'b0000};
        pmem_wdata   = d_pmem_wdata;
      end
      default: ;
    endcase
  end

  assign i_pmem_resp  = pmem_resp & (state_q == SERVE_I);
  assign d_pmem_resp  = pmem_resp & (state_q == SERVE_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_lc3b_pmem_arbiter.sv
// Directed bench for lc3b_pmem_arbiter: one instance in round-robin mode and one
// in fixed-priority mode share the cache-side inputs but have separate pmem_resp.
module tb_lc3b_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_addr;
  logic         d_read, d_write;
  logic [15:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] p_rdata;
  logic         resp0, resp1;

  logic [127:0] i_rdata0, d_rdata0, pwdata0, i_rdata1, d_rdata1, pwdata1;
  logic         i_resp0, d_resp0, pread0, pwrite0;
  logic         i_resp1, d_resp1, pread1, pwrite1;
  logic [15:0]  paddr0, paddr1;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] PAT_A5   = {16{8'hA5}};
  localparam logic [127:0] PAT_BEEF = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] PAT_5A   = {16{8'h5A}};

  always #5 clk = ~clk;

  lc3b_pmem_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_read), .i_pmem_address(i_addr),
    .i_pmem_rdata(i_rdata0), .i_pmem_resp(i_resp0),
    .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata0), .d_pmem_resp(d_resp0),
    .pmem_read(pread0), .pmem_write(pwrite0), .pmem_address(paddr0),
    .pmem_wdata(pwdata0), .pmem_rdata(p_rdata), .pmem_resp(resp0)
  );

  lc3b_pmem_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_read), .i_pmem_address(i_addr),
    .i_pmem_rdata(i_rdata1), .i_pmem_resp(i_resp1),
    .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
    .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata1), .d_pmem_resp(d_resp1),
    .pmem_read(pread1), .pmem_write(pwrite1), .pmem_address(paddr1),
    .pmem_wdata(pwdata1), .pmem_rdata(p_rdata), .pmem_resp(resp1)
  );

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_addr = 16'h0; d_read = 1'b0; d_write = 1'b0;
    d_addr = 16'h0; d_wdata = '0; p_rdata = '0; resp0 = 1'b0; resp1 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({pread0, pwrite0, i_resp0, d_resp0} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {pread0, pwrite0, i_resp0, d_resp0});
    end
    vectors++;
    if (paddr0 !== 16'h0000 || pwdata0 !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr_data: got addr %h data %h expected 0", paddr0, pwdata0);
    end
  endtask

  task automatic test_i_read();
    do_reset();
    i_read = 1'b1; i_addr = 16'h1234;
    #1;
    vectors++;
    if (pread0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL i_read_request_cycle: pmem_read got %b expected 0", pread0);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        resp0 = 1'b1; p_rdata = PAT_A5; i_read = 1'b0;
      end
      #1;
      vectors++;
      if (pread0 !== 1'b1 || pwrite0 !== 1'b0 || paddr0 !== 16'h1230) begin
        miscompares++;
        $display("[TB] FAIL i_read_strobe c%0d: got rd %b wr %b addr %h expected 1 0 1230", c, pread0, pwrite0, paddr0);
      end
      vectors++;
      if (i_resp0 !== (c == 3) || d_resp0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL i_read_resp c%0d: got i %b d %b expected %b 0", c, i_resp0, d_resp0, (c == 3));
      end
    end
    vectors++;
    if (i_rdata0 !== PAT_A5) begin
      miscompares++;
      $display("[TB] FAIL i_read_rdata: got %h expected %h", i_rdata0, PAT_A5);
    end
    step();
    resp0 = 1'b0;
    #1;
    vectors++;
    if (pread0 !== 1'b0 || i_resp0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL i_read_done: got rd %b resp %b expected 0 0", pread0, i_resp0);
    end
  endtask

  task automatic test_d_write(input logic also_read);
    do_reset();
    d_write = 1'b1; d_read = also_read; d_addr = 16'h80FF; d_wdata = PAT_BEEF;
    step();
    #1;
    vectors++;
    if (pwrite0 !== 1'b1 || pread0 !== 1'b0 || paddr0 !== 16'h80F0) begin
      miscompares++;
      $display("[TB] FAIL d_write_strobe rd=%b: got wr %b rd %b addr %h expected 1 0 80f0", also_read, pwrite0, pread0, paddr0);
    end
    vectors++;
    if (pwdata0 !== PAT_BEEF) begin
      miscompares++;
      $display("[TB] FAIL d_write_wdata: got %h expected %h", pwdata0, PAT_BEEF);
    end
    step();
    resp0 = 1'b1;
    #1;
    vectors++;
    if (d_resp0 !== 1'b1 || i_resp0 !== 1'b0 || pwrite0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL d_write_resp: got d %b i %b wr %b expected 1 0 1", d_resp0, i_resp0, pwrite0);
    end
    d_write = 1'b0; d_read = 1'b0;
    step();
    resp0 = 1'b0;
    #1;
    vectors++;
    if (pwrite0 !== 1'b0 || d_resp0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL d_write_done: got wr %b resp %b expected 0 0", pwrite0, d_resp0);
    end
  endtask

  task automatic test_round_robin();
    logic last_d = 1'b1;
    logic grant_d;
    do_reset();
    i_read = 1'b1; i_addr = 16'h1000;
    d_read = 1'b1; d_addr = 16'h2000;
    for (int t = 0; t < 4; t++) begin
      grant_d = ~last_d;
      last_d  = grant_d;
      step();
      #1;
      vectors++;
      if (pread0 !== 1'b1 || paddr0 !== (grant_d ? 16'h2000 : 16'h1000)) begin
        miscompares++;
        $display("[TB] FAIL rr_grant t%0d: got rd %b addr %h expected 1 %h", t, pread0, paddr0, grant_d ? 16'h2000 : 16'h1000);
      end
      step();
      resp0 = 1'b1;
      #1;
      vectors++;
      if (d_resp0 !== grant_d || i_resp0 !== ~grant_d) begin
        miscompares++;
        $display("[TB] FAIL rr_resp t%0d: got i %b d %b expected %b %b", t, i_resp0, d_resp0, ~grant_d, grant_d);
      end
      step();
      resp0 = 1'b0;
      #1;
      vectors++;
      if (pread0 !== 1'b0 || pwrite0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rr_idle_gap t%0d: got rd %b wr %b expected 0 0", t, pread0, pwrite0);
      end
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    i_read = 1'b1; i_addr = 16'h1000;
    d_read = 1'b1; d_addr = 16'h2000;
    for (int t = 0; t < 3; t++) begin
      step();
      #1;
      vectors++;
      if (pread1 !== 1'b1 || paddr1 !== 16'h2000) begin
        miscompares++;
        $display("[TB] FAIL fixed_grant t%0d: got rd %b addr %h expected 1 2000", t, pread1, paddr1);
      end
      step();
      resp1 = 1'b1;
      #1;
      vectors++;
      if (d_resp1 !== 1'b1 || i_resp1 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fixed_resp t%0d: got i %b d %b expected 0 1", t, i_resp1, d_resp1);
      end
      step();
      resp1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_write = 1'b1; d_addr = 16'h4000; d_wdata = PAT_5A;
    step();
    #1;
    vectors++;
    if (pwrite0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_serve: pmem_write got %b expected 1", pwrite0);
    end
    rst_n = 1'b0; d_write = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (pwrite0 !== 1'b0 || pread0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_strobes: got wr %b rd %b expected 0 0", pwrite0, pread0);
    end
    step();
    resp0 = 1'b1;
    #1;
    vectors++;
    if (d_resp0 !== 1'b0 || i_resp0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_late_resp: got i %b d %b expected 0 0", i_resp0, d_resp0);
    end
    step();
    resp0 = 1'b0; i_read = 1'b1; i_addr = 16'h5678;
    step();
    #1;
    vectors++;
    if (pread0 !== 1'b1 || paddr0 !== 16'h5670) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_regrant: got rd %b addr %h expected 1 5670", pread0, paddr0);
    end
    step();
    resp0 = 1'b1; i_read = 1'b0;
    #1;
    vectors++;
    if (i_resp0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_i_resp: got %b expected 1", i_resp0);
    end
    step();
    resp0 = 1'b0;
  endtask

  task automatic test_stray_resp();
    do_reset();
    resp0 = 1'b1;
    #1;
    vectors++;
    if (i_resp0 !== 1'b0 || d_resp0 !== 1'b0 || pread0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_resp: got i %b d %b rd %b expected 0 0 0", i_resp0, d_resp0, pread0);
    end
    step();
    resp0 = 1'b0;
    #1;
    vectors++;
    if (pread0 !== 1'b0 || pwrite0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_resp_idle: got rd %b wr %b expected 0 0", pread0, pwrite0);
    end
    i_read = 1'b1; i_addr = 16'h0ABC;
    step();
    #1;
    vectors++;
    if (pread0 !== 1'b1 || paddr0 !== 16'h0AB0) begin
      miscompares++;
      $display("[TB] FAIL stray_resp_then_grant: got rd %b addr %h expected 1 0ab0", pread0, paddr0);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_i_read();
    test_d_write(1'b0);
    test_d_write(1'b1);
    test_round_robin();
    test_fixed_prio();
    test_reset_mid();
    test_stray_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
